// File: rtl/xxd_pkg.sv
// Shared types, character constants and helpers for the xxd hex-dump engine.
// The optional ASCII column is selected with the XXD_ASCII_COL_EN macro.
package xxd_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_OFFSET,
      ST_COLON,
      ST_SPACE,
      ST_HEX_HI,
      ST_HEX_LO,
      ST_SEP,
      ST_GET_BYTE,
      ST_PAD,
      ST_ASC_SP,
      ST_ASCII,
      ST_NEWLINE
   } xxd_state_t;

   localparam logic [7:0] CH_COLON = 8'h3a;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_NL    = 8'h0a;
   localparam logic [7:0] CH_DOT   = 8'h2e;

   localparam int MAX_BYTES_PER_LINE = 32;
   localparam int MAX_OFFSET_DIGITS  = 8;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h57 + {4'h0, nib};
   endfunction

   function automatic logic [7:0] asc_char(input logic [7:0] b);
      return (b >= 8'h20 && b <= 8'h7e) ? b : CH_DOT;
   endfunction

   function automatic bit params_ok(input int bpl, input int grp, input int od);
      return bpl >= 1 && bpl <= MAX_BYTES_PER_LINE &&
             grp >= 1 && grp <= bpl &&
             od >= 1 && od <= MAX_OFFSET_DIGITS;
   endfunction

endpackage

// File: rtl/xxd_hex_char.sv
// Nibble to lowercase ASCII hex digit, shared by the offset and byte paths.
module xxd_hex_char
   import xxd_pkg::*;
(
   input  logic [3:0] nib,
   output logic [7:0] ch
);

   assign ch = hex_char(nib);

endmodule

// File: rtl/xxd_hexdump_stream.sv
// Streaming xxd-style hex dump: bytes in, one ASCII character per handshake out.
// Define XXD_ASCII_COL_EN to add the padded printable-character column.
module xxd_hexdump_stream
   import xxd_pkg::*;
#(
   parameter int BYTES_PER_LINE = 16,
   parameter int GROUP          = 2,
   parameter int OFFSET_DIGITS  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   input  logic       in_last,
   output logic       in_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy
);

   localparam int OW = 4 * OFFSET_DIGITS;
   localparam int IW = 6;

   if (!params_ok(BYTES_PER_LINE, GROUP, OFFSET_DIGITS)) begin : g_bad_params
      $error("xxd_hexdump_stream: illegal parameter set");
   end

   xxd_state_t    state, state_d;
   logic [OW-1:0] offset, off_sh;
   logic [IW-1:0] idx, grp;
   logic [2:0]    dig;
   logic [7:0]    cur, off_ch, byte_ch;
   logic          last_q, busy_q, line_end, grp_end;

   assign off_sh   = offset >> {dig, 2'b00};
   assign line_end = last_q || (idx == IW'(BYTES_PER_LINE - 1));
   assign grp_end  = (grp == IW'(GROUP - 1));
   assign busy     = busy_q;

   xxd_hex_char u_off_hex (.nib(off_sh[3:0]), .ch(off_ch));
   xxd_hex_char u_byte_hex (
      .nib((state == ST_HEX_HI) ? cur[7:4] : cur[3:0]),
      .ch (byte_ch)
   );

`ifdef XXD_ASCII_COL_EN
   localparam int HEX_FULL = 2 * BYTES_PER_LINE + (BYTES_PER_LINE - 1) / GROUP;
   localparam int LBW = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;

   logic [7:0]    line_buf [BYTES_PER_LINE];
   logic [6:0]    hex_cnt;
   logic [IW-1:0] aidx, idx_n;
   logic          sp_cnt, hex_done;

   // hex_done: the character now on the bus completes the hex column width
   assign hex_done = (hex_cnt == 7'(HEX_FULL - 1));
   assign idx_n    = idx + IW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hex_cnt <= '0;
         aidx    <= '0;
         sp_cnt  <= 1'b0;
         for (int i = 0; i < BYTES_PER_LINE; i++) line_buf[i] <= '0;
      end else begin
         unique case (state)
            ST_IDLE: if (in_valid) begin
               hex_cnt     <= '0;
               aidx        <= '0;
               sp_cnt      <= 1'b0;
               line_buf[0] <= in_data;
            end
            ST_GET_BYTE: if (in_valid) line_buf[idx_n[LBW-1:0]] <= in_data;
            ST_HEX_HI, ST_HEX_LO, ST_SEP, ST_PAD:
               if (out_ready) hex_cnt <= hex_cnt + 7'd1;
            ST_ASC_SP: if (out_ready) sp_cnt <= ~sp_cnt;
            ST_ASCII:  if (out_ready) aidx <= aidx + IW'(1);
            default: ;
         endcase
      end
   end
`endif

   always_comb begin
      state_d   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = 8'h00;
      unique case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ST_OFFSET;
         end
         ST_OFFSET: begin
            out_valid = 1'b1;
            out_data  = off_ch;
            if (out_ready && dig == 3'd0) state_d = ST_COLON;
         end
         ST_COLON: begin
            out_valid = 1'b1;
            out_data  = CH_COLON;
            if (out_ready) state_d = ST_SPACE;
         end
         ST_SPACE: begin
            out_valid = 1'b1;
            out_data  = CH_SPACE;
            if (out_ready) state_d = ST_HEX_HI;
         end
         ST_HEX_HI: begin
            out_valid = 1'b1;
            out_data  = byte_ch;
            if (out_ready) state_d = ST_HEX_LO;
         end
         ST_HEX_LO: begin
            out_valid = 1'b1;
            out_data  = byte_ch;
            if (out_ready) begin
               if (line_end) begin
`ifdef XXD_ASCII_COL_EN
                  state_d = hex_done ? ST_ASC_SP : ST_PAD;
`else
                  state_d = ST_NEWLINE;
`endif
               end else begin
                  state_d = grp_end ? ST_SEP : ST_GET_BYTE;
               end
            end
         end
         ST_SEP: begin
            out_valid = 1'b1;
            out_data  = CH_SPACE;
            if (out_ready) state_d = ST_GET_BYTE;
         end
         ST_GET_BYTE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ST_HEX_HI;
         end
`ifdef XXD_ASCII_COL_EN
         ST_PAD: begin
            out_valid = 1'b1;
            out_data  = CH_SPACE;
            if (out_ready && hex_done) state_d = ST_ASC_SP;
         end
         ST_ASC_SP: begin
            out_valid = 1'b1;
            out_data  = CH_SPACE;
            if (out_ready && sp_cnt) state_d = ST_ASCII;
         end
         ST_ASCII: begin
            out_valid = 1'b1;
            out_data  = asc_char(line_buf[aidx[LBW-1:0]]);
            if (out_ready && aidx == idx) state_d = ST_NEWLINE;
         end
`endif
         ST_NEWLINE: begin
            out_valid = 1'b1;
            out_data  = CH_NL;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         offset <= '0;
         idx    <= '0;
         grp    <= '0;
         dig    <= '0;
         cur    <= '0;
         last_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state <= state_d;
         unique case (state)
            ST_IDLE: if (in_valid) begin
               cur    <= in_data;
               last_q <= in_last;
               idx    <= '0;
               grp    <= '0;
               dig    <= 3'(OFFSET_DIGITS - 1);
               busy_q <= 1'b1;
            end
            ST_OFFSET: if (out_ready && dig != 3'd0) dig <= dig - 3'd1;
            ST_HEX_LO: if (out_ready) grp <= grp_end ? '0 : grp + IW'(1);
            ST_GET_BYTE: if (in_valid) begin
               cur    <= in_data;
               last_q <= in_last;
               idx    <= idx + IW'(1);
            end
            // a full line advances the offset; the dump's final line rewinds it
            ST_NEWLINE: if (out_ready) begin
               idx <= '0;
               if (last_q) begin
                  offset <= '0;
                  busy_q <= 1'b0;
               end else begin
                  offset <= offset + OW'(BYTES_PER_LINE);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_xxd_hexdump_stream.sv
// Directed bench for xxd_hexdump_stream: vector table plus reset and offset-wrap sequences.
// Build with XXD_ASCII_COL_EN to exercise the ASCII column variant.
module tb_xxd_hexdump_stream;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b0;
   logic       sel = 1'b0;

   logic       in_ready_a, out_valid_a, busy_a;
   logic       in_ready_b, out_valid_b, busy_b;
   logic [7:0] out_data_a, out_data_b;
   logic       in_ready, out_valid, busy;
   logic [7:0] out_data;

   assign in_ready  = sel ? in_ready_b  : in_ready_a;
   assign out_valid = sel ? out_valid_b : out_valid_a;
   assign out_data  = sel ? out_data_b  : out_data_a;
   assign busy      = sel ? busy_b      : busy_a;

   always #5 clk = ~clk;

   xxd_hexdump_stream u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid & ~sel),
      .in_last  (in_last),
      .in_ready (in_ready_a),
      .out_data (out_data_a),
      .out_valid(out_valid_a),
      .out_ready(out_ready & ~sel),
      .busy     (busy_a)
   );

   xxd_hexdump_stream #(.OFFSET_DIGITS(2)) u_dut_o2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid & sel),
      .in_last  (in_last),
      .in_ready (in_ready_b),
      .out_data (out_data_b),
      .out_valid(out_valid_b),
      .out_ready(out_ready & sel),
      .busy     (busy_b)
   );

   typedef struct {
      string           name;
      int              n;
      logic [31:0][7:0] b;
      string           exp;
      bit              stall;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] stim [0:299];
   int         stim_n;
   bit         stim_last;
   bit         stall;
   string      got;
   int         max_chars;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      int d;
      checks++;
      if (act != exp) begin
         errors++;
         d = 0;
         while (d < act.len() && d < exp.len() && act[d] == exp[d]) d++;
         $display("FAIL %s: got len %0d expected len %0d, first diff at %0d (got %0h expected %0h)",
                  name, act.len(), exp.len(), d,
                  (d < act.len()) ? act[d] : 8'h00, (d < exp.len()) ? exp[d] : 8'h00);
      end
   endtask

   task automatic drive();
      int i = 0;
      int guard = 0;
      while (i < stim_n && guard < 3000) begin
         @(negedge clk);
         in_valid = !(stall && $urandom_range(0, 2) == 0);
         in_data  = stim[i];
         in_last  = stim_last && (i == stim_n - 1);
         #1;
         if (in_valid && in_ready) i++;
         guard++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i < stim_n) begin
         checks++;
         errors++;
         $display("FAIL drive_timeout: accepted %0d required %0d", i, stim_n);
      end
   endtask

   task automatic sink();
      int   guard = 0;
      bit   pend = 1'b0;
      logic [7:0] pd = 8'h00;
      got = "";
      while (got.len() < max_chars && guard < 3000) begin
         @(negedge clk);
         out_ready = !(stall && $urandom_range(0, 1) == 0);
         #1;
         if (pend && out_valid) chk("stall_hold", out_data, pd);
         pend = out_valid && !out_ready;
         pd   = out_data;
         if (out_valid && out_ready) got = $sformatf("%s%c", got, out_data);
         guard++;
      end
      if (got.len() < max_chars) begin
         checks++;
         errors++;
         $display("FAIL sink_timeout: chars %0d required %0d", got.len(), max_chars);
      end
   endtask

   task automatic run(input string name, input string exp, input bit chk_busy);
      max_chars = exp.len();
      fork
         drive();
         sink();
      join
      chk_str(name, got, exp);
      if (chk_busy) begin
         @(negedge clk);
         #1;
         chk({name, "_busy"}, busy, 1'b0);
      end
   endtask

   function automatic string fmt2(input int n);
      string s = "";
      for (int p = 0; p < n; p += 16) begin
         int e;
         e = (p + 16 < n) ? p + 15 : n - 1;
         s = {s, $sformatf("%02x: ", p & 255)};
         for (int i = p; i <= e; i++) begin
            s = {s, $sformatf("%02x", stim[i])};
            if (((i - p) % 2 == 1) && i != e) s = {s, " "};
         end
         s = {s, "\n"};
      end
      return s;
   endfunction

`ifdef XXD_ASCII_COL_EN
   localparam int VN = 1;
`else
   localparam int VN = 5;
`endif
   vec_t vt [VN];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      string line1, s, exp5;
`ifdef XXD_ASCII_COL_EN
      s = "00000000: 4869 0a";
      for (int i = 0; i < 32; i++) s = {s, " "};
      vt[0] = '{"ascii_hi", 3, '0, {s, "  Hi.\n"}, 1'b0};
      vt[0].b[0] = 8'h48; vt[0].b[1] = 8'h69; vt[0].b[2] = 8'h0a;
      line1 = "00000000: 0001 0203 0405 0607 0809 0a0b 0c0d 0e0f  ................\n";
`else
      line1 = "00000000: 0001 0203 0405 0607 0809 0a0b 0c0d 0e0f\n";
      vt[0] = '{"hi", 2, '0, "00000000: 4869\n", 1'b0};
      vt[0].b[0] = 8'h48; vt[0].b[1] = 8'h69;
      vt[1] = '{"two_lines", 17, '0, {line1, "00000010: 10\n"}, 1'b0};
      for (int i = 0; i < 17; i++) vt[1].b[i] = 8'(i);
      vt[2] = vt[1];
      vt[2].name  = "two_lines_stall";
      vt[2].stall = 1'b1;
      vt[3] = '{"single_ff", 1, '0, "00000000: ff\n", 1'b0};
      vt[3].b[0] = 8'hff;
      vt[4] = '{"group_tail", 3, '0, "00000000: 9abc de\n", 1'b0};
      vt[4].b[0] = 8'h9a; vt[4].b[1] = 8'hbc; vt[4].b[2] = 8'hde;
`endif

      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("idle_in_ready", in_ready, 1'b1);
      chk("idle_out_valid", out_valid, 1'b0);

      for (int v = 0; v < VN; v++) begin
         for (int i = 0; i < vt[v].n; i++) stim[i] = vt[v].b[i];
         stim_n    = vt[v].n;
         stim_last = 1'b1;
         stall     = vt[v].stall;
         run(vt[v].name, vt[v].exp, 1'b1);
      end
      stall = 1'b0;

`ifndef XXD_ASCII_COL_EN
      sel = 1'b1;
      for (int i = 0; i < 272; i++) stim[i] = 8'(i);
      stim_n    = 272;
      stim_last = 1'b1;
      exp5      = fmt2(272);
      run("offset_wrap", exp5, 1'b1);
      chk_str("line17_offset", got.substr(16 * 44, 16 * 44 + 3), "00: ");
      sel = 1'b0;
`endif

      for (int i = 0; i < 17; i++) stim[i] = 8'(i);
      stim_n    = 17;
      stim_last = 1'b0;
      run("pre_reset", {line1, "00000010: 1"}, 1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("hex_lo_valid", out_valid, 1'b1);
      chk("hex_lo_data", out_data, 8'h30);
      chk("mid_busy", busy, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_data", out_data, 8'h00);
      chk("async_rst_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      stim[0]   = 8'hab;
      stim_n    = 1;
      stim_last = 1'b1;
`ifdef XXD_ASCII_COL_EN
      s = "00000000: ab";
      for (int i = 0; i < 37; i++) s = {s, " "};
      run("after_reset", {s, "  .\n"}, 1'b1);
`else
      run("after_reset", "00000000: ab\n", 1'b1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
